m6809_bus_arbiter: RTL and testbench
====================================

# m6809_bus_arbiter

Bus arbiter that shares the 6809 system bus between the CPU and NREQ DMA-style requesters. It halts the CPU through `halt_b`, waits for the CPU's bus-available acknowledge (BA=1, BS=1), grants one requester at a time using round-robin with a bounded burst length, then returns the bus to the CPU. It sits in `m6809_integration`, between the requesters and the CPU's `halt_b` pin and the address/data bus ownership mux.

## Interface
- `NREQ`, 2: number of bus requesters (2..8).
- `MAX_BURST`, 16: maximum consecutive grant cycles per tenure (≥1).
- `ACK_TIMEOUT`, 64: maximum cycles to wait for the CPU acknowledge, or for BA to release.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  bus request, one bit per requester; level-sensitive.
- `cpu_ba`  in  1  CPU bus-available output.
- `cpu_bs`  in  1  CPU bus-status output.
- `halt_b`  out  1  active-low halt request to the CPU.
- `gnt`  out  NREQ  one-hot grant; all zero when no requester owns the bus.
- `bus_own`  out  1  mux select: 1 = the granted requester drives the bus.
- `timeout_err`  out  1  one-cycle pulse on an acknowledge or release timeout.

## Operation
- **IDLE**
  - If any `req` bit is set, latch the winner. The winner is the first set bit at or after `ptr`, searching upward and wrapping.
  - Drive `halt_b`=0 and go to HALT_WAIT.
- **HALT_WAIT**
  - On the first cycle with `cpu_ba`=1 and `cpu_bs`=1: go to GRANT, set `gnt[winner]`=1 and `bus_own`=1, and clear the counter.
  - If the winner's `req` drops first: go to RELEASE without granting.
  - If the counter reaches ACK_TIMEOUT-1: pulse `timeout_err`, set `halt_b`=1, go to IDLE. `ptr` is unchanged.
- **GRANT**
  - The counter increments each cycle.
  - Exit to RELEASE when the winner's `req`=0 or the counter reaches MAX_BURST-1.
  - On exit, `gnt` and `bus_own` clear on the same edge.
  - Requests from other requesters are ignored during GRANT.
- **RELEASE**
  - Drive `halt_b`=1 and `gnt`=0, and set `ptr` to winner+1 (mod NREQ).
  - Go to IDLE on the first cycle with `cpu_ba`=0.
  - If the counter reaches ACK_TIMEOUT-1 first: pulse `timeout_err` and go to IDLE.
- **Invariants**
  - The CPU always regains the bus between two tenures, so it cannot be starved.
  - `gnt` is never multi-hot.
  - `gnt`≠0 implies `bus_own`=1 and `halt_b`=0.
- **Counter width**: `$clog2(max(MAX_BURST, ACK_TIMEOUT)+1)`, unsigned, and it never wraps.

## Timing
- **Reset values**
  - `halt_b`=1, `gnt`=0, `bus_own`=0, `timeout_err`=0, `ptr`=0, state IDLE.
  - Assertion clears all of these immediately, including mid-GRANT. There is no drain.
- All outputs are registered.
- **Latencies**
  - `req` sampled high at edge N (IDLE) gives `halt_b` low after edge N.
  - Acknowledge sampled at edge M gives `gnt` high after edge M.
- **Burst length**: with `req` held, `gnt` stays high for exactly MAX_BURST cycles.
- **Early drop**: a `req` drop sampled at edge K gives `gnt` low after edge K. The requester must tolerate one cycle of `gnt` after dropping `req`.
- **Release turnaround**: minimum 1 cycle with `gnt`=0 and `bus_own`=0 before the CPU resumes.
- **Boundary cases**
  - Acknowledge and the winner's `req` drop in the same cycle: the drop wins, go to RELEASE.
  - All `req` set at once with `ptr`=0: requester 0 is served first.

## Structure
- `m6809_pkg` holds:
  - the arbiter state enum (IDLE, HALT_WAIT, GRANT, RELEASE);
  - the BA/BS encodings (RUN=00, INT_ACK=01, SYNC_ACK=10, BUS_GRANT=11).
- Sub-module `m6809_rr_pick`: combinational round-robin picker. Inputs `req` and `ptr`; outputs `valid` and the winner index.

## Test plan
- **Single burst**
  - Stimulus: `req`=01 held; the CPU model answers BA/BS=11 three cycles after `halt_b` falls.
  - Required: `gnt`=01 for exactly 16 cycles; `halt_b` returns to 1; `ptr`=1; IDLE once BA=0.
- **Round-robin**
  - Stimulus: `req`=11 held continuously.
  - Required: grants alternate 01, 10, 01. Each tenure is 16 cycles and separated by a RELEASE/IDLE CPU window.
- **Early drop**
  - Stimulus: `req[1]` dropped on the 5th GRANT cycle.
  - Required: `gnt`=10 for 5 cycles, then 00.
- **Acknowledge timeout**
  - Stimulus: the CPU model never raises BA/BS.
  - Required: a single `timeout_err` pulse 64 cycles after `halt_b` falls; `halt_b`=1; `gnt` never set.
- **Reset mid-grant**
  - Stimulus: assert `reset` asynchronously while `gnt`=01.
  - Required: `gnt`=0, `bus_own`=0, `halt_b`=1 before the next clock edge; `ptr`=0 after release.
- **Withdrawn request**
  - Stimulus: `req` dropped during HALT_WAIT.
  - Required: no grant; straight to RELEASE; `halt_b`=1.

Source files
------------

// File: rtl/m6809_pkg.sv
// Shared types for the 6809 bus arbiter: arbiter states, CPU BA/BS status
// encodings, and a sizing helper.
package m6809_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HALT_WAIT = 2'd1,
    ST_GRANT     = 2'd2,
    ST_RELEASE   = 2'd3
  } arb_state_e;

  // {BA, BS} as driven by the 6809
  typedef enum logic [1:0] {
    BABS_RUN       = 2'b00,
    BABS_INT_ACK   = 2'b01,
    BABS_SYNC_ACK  = 2'b10,
    BABS_BUS_GRANT = 2'b11
  } babs_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/m6809_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// searching upward and wrapping.
module m6809_rr_pick #(
  parameter int NREQ  = 2,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] winner
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [PTR_W-1:0]  off;
  logic [PTR_W:0]    sum;

  // Rotating right by ptr puts the highest-priority request at bit 0
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NREQ-1:0];

  always_comb begin
    valid  = |req;
    off    = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) off = PTR_W'(j);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PTR_W + 1)'(NREQ)) sum = sum - (PTR_W + 1)'(NREQ);
    winner = sum[PTR_W-1:0];
  end

endmodule

// File: rtl/m6809_bus_arbiter.sv
// Shares the 6809 bus between the CPU and NREQ requesters: halts the CPU,
// waits for BA/BS=11, grants one requester for a bounded burst, then releases.
module m6809_bus_arbiter
  import m6809_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int MAX_BURST   = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            cpu_ba,
  input  logic            cpu_bs,
  output logic            halt_b,
  output logic [NREQ-1:0] gnt,
  output logic            bus_own,
  output logic            timeout_err
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(max_u(MAX_BURST, ACK_TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_TOP    = PTR_W'(NREQ - 1);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] winner_q, winner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halt_b_q, halt_b_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             own_q, own_d;
  logic             tmo_q, tmo_d;

  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;
  logic             win_req;
  logic             bus_granted;
  logic [PTR_W-1:0] ptr_after;

  m6809_rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  assign win_req     = req[winner_q];
  assign bus_granted = (babs_e'({cpu_ba, cpu_bs}) == BABS_BUS_GRANT);
  assign ptr_after   = (winner_q == PTR_TOP) ? '0 : winner_q + PTR_W'(1);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    halt_b_d = halt_b_q;
    gnt_d    = gnt_q;
    own_d    = own_q;
    tmo_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          winner_d = pick_idx;
          cnt_d    = '0;
          halt_b_d = 1'b0;
          state_d  = ST_HALT_WAIT;
        end
      end
      // A withdrawn request takes priority over a same-cycle acknowledge
      ST_HALT_WAIT: begin
        if (!win_req) begin
          halt_b_d = 1'b1;
          ptr_d    = ptr_after;
          cnt_d    = '0;
          state_d  = ST_RELEASE;
        end else if (bus_granted) begin
          gnt_d    = NREQ'(1) << winner_q;
          own_d    = 1'b1;
          cnt_d    = '0;
          state_d  = ST_GRANT;
        end else if (cnt_q == ACK_LAST) begin
          tmo_d    = 1'b1;
          halt_b_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (!win_req || cnt_q == BURST_LAST) begin
          gnt_d    = '0;
          own_d    = 1'b0;
          halt_b_d = 1'b1;
          ptr_d    = ptr_after;
          cnt_d    = '0;
          state_d  = ST_RELEASE;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!cpu_ba) begin
          state_d = ST_IDLE;
        end else if (cnt_q == ACK_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      halt_b_q <= 1'b1;
      gnt_q    <= '0;
      own_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      halt_b_q <= halt_b_d;
      gnt_q    <= gnt_d;
      own_q    <= own_d;
      tmo_q    <= tmo_d;
    end
  end

  // Winner index is only consulted outside IDLE, after it has been loaded
  always_ff @(posedge clk) begin
    winner_q <= winner_d;
  end

  assign halt_b      = halt_b_q;
  assign gnt         = gnt_q;
  assign bus_own     = own_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_m6809_bus_arbiter.sv
// Self-checking bench for m6809_bus_arbiter with a reactive CPU BA/BS model
// and a round-robin reference pointer kept at transaction level.
module tb_m6809_bus_arbiter;
  localparam int NREQ        = 2;
  localparam int MAX_BURST   = 16;
  localparam int ACK_TIMEOUT = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic            cpu_ba = 1'b0;
  logic            cpu_bs = 1'b0;
  logic            halt_b;
  logic [NREQ-1:0] gnt;
  logic            bus_own;
  logic            timeout_err;

  int checks = 0;
  int failures = 0;

  bit cpu_ack_en = 1'b1;
  int ack_dly = 3;
  int rel_dly = 0;
  int hl_cnt = 0;
  int rel_cnt = 0;
  bit mon_en = 1'b0;
  int ptr_m = 0;

  m6809_bus_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .cpu_ba      (cpu_ba),
    .cpu_bs      (cpu_bs),
    .halt_b      (halt_b),
    .gnt         (gnt),
    .bus_own     (bus_own),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // CPU: acknowledges ack_dly cycles after seeing halt_b low, releases BA
  // rel_dly cycles after seeing halt_b high again
  always @(negedge clk) begin
    if (!halt_b) begin
      rel_cnt = 0;
      hl_cnt  = hl_cnt + 1;
      if (cpu_ack_en && hl_cnt > ack_dly) begin
        cpu_ba <= 1'b1;
        cpu_bs <= 1'b1;
      end
    end else begin
      hl_cnt = 0;
      if (cpu_ba) begin
        rel_cnt = rel_cnt + 1;
        if (rel_cnt > rel_dly) begin
          cpu_ba  <= 1'b0;
          cpu_bs  <= 1'b0;
          rel_cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check("gnt_onehot", 32'($onehot0(gnt)), 1);
      check("own_vs_gnt", 32'(bus_own), 32'(gnt != '0));
      if (gnt != '0) check("halt_in_grant", 32'(halt_b), 0);
    end
  end

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return 0;
  endfunction

  // Waits for a grant, then counts its length; drops req[w] after drop_k grant cycles
  task automatic tenure(input int w, input int drop_k, output logic [NREQ-1:0] g,
                        output int len, output int lat);
    lat = 0;
    while (gnt == '0 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    g   = gnt;
    len = 0;
    while (gnt != '0 && gnt == g && len < 300) begin
      len++;
      if (len == drop_k) req[w] = 1'b0;
      @(negedge clk);
    end
    check("rel_gnt_clear", 32'(gnt), 0);
    check("rel_own_clear", 32'(bus_own), 0);
    check("rel_halt_high", 32'(halt_b), 1);
  endtask

  task automatic settle();
    req = '0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [NREQ-1:0] g;
    logic [NREQ-1:0] pat;
    int len, lat, k, w, c;
    logic seen;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_halt_b", 32'(halt_b), 1);
    check("reset_gnt", 32'(gnt), 0);
    check("reset_bus_own", 32'(bus_own), 0);
    check("reset_timeout", 32'(timeout_err), 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Single burst, CPU answers 3 cycles after halt
    ack_dly = 3;
    rel_dly = 1;
    req = 2'b01;
    @(negedge clk);
    check("burst_halt_lat", 32'(halt_b), 0);
    tenure(0, 0, g, len, lat);
    check("burst_gnt", 32'(g), 1);
    check("burst_len", len, MAX_BURST);
    check("burst_ack_lat", lat, ack_dly + 1);
    ptr_m = 1;
    settle();

    // Pointer moved past requester 0: both requesting -> requester 1 wins
    ack_dly = 0;
    req = 2'b11;
    tenure(1, 3, g, len, lat);
    check("ptr_adv_gnt", 32'(g), 2);
    check("ptr_adv_len", len, 3);
    ptr_m = 0;
    settle();

    // Randomized tenures against the round-robin reference
    for (int it = 0; it < 10; it++) begin
      pat     = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      ack_dly = $urandom_range(0, 4);
      rel_dly = $urandom_range(0, 2);
      k       = $urandom_range(1, MAX_BURST + 4);
      w       = pick(pat, ptr_m);
      req     = pat;
      tenure(w, k, g, len, lat);
      check("rand_gnt", 32'(g), 1 << w);
      check("rand_len", len, (k < MAX_BURST) ? k : MAX_BURST);
      check("rand_lat", lat, ack_dly + 2);
      ptr_m = (w + 1) % NREQ;
      settle();
    end

    // Early drop on the 5th grant cycle
    ack_dly = 2;
    rel_dly = 0;
    req = 2'b10;
    tenure(1, 5, g, len, lat);
    check("early_gnt", 32'(g), 2);
    check("early_len", len, 5);
    ptr_m = 0;
    settle();

    // Withdrawn during HALT_WAIT, then drop coinciding with acknowledge
    for (int v = 0; v < 2; v++) begin
      ack_dly = (v == 0) ? 10 : 2;
      req = 2'b01;
      @(negedge clk);
      check("wd_halt_low", 32'(halt_b), 0);
      repeat ((v == 0) ? 3 : 2) @(negedge clk);
      req  = '0;
      seen = 1'b0;
      @(negedge clk);
      check("wd_halt_high", 32'(halt_b), 1);
      repeat (10) begin
        seen = seen | (gnt != '0);
        @(negedge clk);
      end
      check("wd_no_grant", 32'(seen), 0);
      ptr_m = 1;
    end

    // Acknowledge timeout
    cpu_ack_en = 1'b0;
    req = 2'b10;
    @(negedge clk);
    check("tmo_halt_low", 32'(halt_b), 0);
    c = 0;
    seen = 1'b0;
    while (!timeout_err && c < 300) begin
      seen = seen | (gnt != '0);
      @(negedge clk);
      c++;
    end
    req = '0;
    check("tmo_lat", c, ACK_TIMEOUT);
    check("tmo_halt_high", 32'(halt_b), 1);
    check("tmo_no_grant", 32'(seen), 0);
    @(negedge clk);
    check("tmo_pulse_width", 32'(timeout_err), 0);
    cpu_ack_en = 1'b1;
    settle();

    // Timeout leaves the pointer alone: requester 1 still first
    ack_dly = 1;
    req = 2'b11;
    tenure(1, 2, g, len, lat);
    check("tmo_ptr_gnt", 32'(g), 2);
    ptr_m = 0;
    settle();

    // Asynchronous reset in the middle of a grant
    ack_dly = 0;
    req = 2'b01;
    c = 0;
    while (gnt == '0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("rst_pre_gnt", 32'(gnt), 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_async_gnt", 32'(gnt), 0);
    check("rst_async_own", 32'(bus_own), 0);
    check("rst_async_halt", 32'(halt_b), 1);
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ptr_m = 0;
    repeat (4) @(negedge clk);

    // Round-robin with both requests held: 01, 10, 01
    ack_dly = 1;
    rel_dly = 1;
    req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      tenure(t % 2, 0, g, len, lat);
      check("rr3_gnt", 32'(g), 1 << (t % 2));
      check("rr3_len", len, MAX_BURST);
    end
    settle();

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
